// File: rtl/pipe_pkg.sv
// Shared constants for the WB-side register file and its pending-write scoreboard.
package pipe_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int W          = 32;
    localparam int NREG       = 32;
    localparam int CNTW       = 2;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [CNTW-1:0]       CNT_MAX  = {CNTW{1'b1}};
endpackage

// File: rtl/pipe_sb_counter.sv
// One scoreboard entry: saturating up/down count of writes in flight to a register.
module pipe_sb_counter #(
    parameter int CNTW = pipe_pkg::CNTW
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CNTW-1:0] cnt_o,
    output logic            nz_o
);
    logic [CNTW-1:0] cnt_q, cnt_d;

    // A retire with nothing pending is an untracked write: hold at zero, never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != {CNTW{1'b1}})
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign nz_o  = |cnt_q;
endmodule

// File: rtl/pipe_wb_regfile_sb.sv
// 32x32 register file written by WB, two bypassed ID read ports and a per-register pending-write scoreboard.
module pipe_wb_regfile_sb
    import pipe_pkg::*;
#(
    parameter int W    = pipe_pkg::W,
    parameter int NREG = pipe_pkg::NREG,
    parameter int CNTW = pipe_pkg::CNTW
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  WBwreg,
    input  logic [REG_ADDR_W-1:0] WBwn,
    input  logic [W-1:0]          WBdata,
    input  logic [REG_ADDR_W-1:0] IDrs,
    input  logic [REG_ADDR_W-1:0] IDrt,
    input  logic                  IDusesRs,
    input  logic                  IDusesRt,
    input  logic                  IDissue,
    input  logic                  IDwreg,
    input  logic [REG_ADDR_W-1:0] IDwn,
    output logic [W-1:0]          qa,
    output logic [W-1:0]          qb,
    output logic                  stall,
    output logic                  busy
);
    logic [W-1:0]               regs_q [NREG];
    logic [NREG-1:0][CNTW-1:0]  cnt;
    logic [NREG-1:0]            nz, inc, dec;
    logic                       issue_ok, haz_rs, haz_rt, sat;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (WBwreg && WBwn != REG_ZERO) begin
            regs_q[WBwn] <= WBdata;
        end
    end

    // Bypass is gated by clrn so the read ports are zero while reset is held.
    always_comb begin
        qa = '0;
        if (clrn && IDrs != REG_ZERO)
            qa = (WBwreg && WBwn == IDrs) ? WBdata : regs_q[IDrs];
    end

    always_comb begin
        qb = '0;
        if (clrn && IDrt != REG_ZERO)
            qb = (WBwreg && WBwn == IDrt) ? WBdata : regs_q[IDrt];
    end

    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;
    assign inc[0] = 1'b0;
    assign dec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        assign inc[r] = issue_ok && IDwreg && IDwn == REG_ADDR_W'(r);
        assign dec[r] = WBwreg && WBwn == REG_ADDR_W'(r);
        pipe_sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk   (clk),
            .clrn  (clrn),
            .inc_i (inc[r]),
            .dec_i (dec[r]),
            .cnt_o (cnt[r]),
            .nz_o  (nz[r])
        );
    end

    // A retire of the last pending write clears the hazard now; the data arrives via bypass.
    assign haz_rs = IDusesRs && IDrs != REG_ZERO &&
                    cnt[IDrs] > (dec[IDrs] ? CNTW'(1) : CNTW'(0));
    assign haz_rt = IDusesRt && IDrt != REG_ZERO &&
                    cnt[IDrt] > (dec[IDrt] ? CNTW'(1) : CNTW'(0));
    assign sat    = IDwreg && IDwn != REG_ZERO && cnt[IDwn] == CNTW'(CNT_MAX);

    assign stall    = IDissue && (haz_rs || haz_rt || sat);
    assign issue_ok = IDissue && !stall;
    assign busy     = |nz;
endmodule

// File: tb/tb_pipe_wb_regfile_sb.sv
// Directed vector bench for pipe_wb_regfile_sb: bypass, RAW/WAW stalls, scoreboard corners and async reset.
module tb_pipe_wb_regfile_sb;
    logic        clk = 1'b0;
    logic        clrn;
    logic        WBwreg;
    logic [4:0]  WBwn;
    logic [31:0] WBdata;
    logic [4:0]  IDrs, IDrt;
    logic        IDusesRs, IDusesRt, IDissue, IDwreg;
    logic [4:0]  IDwn;
    logic [31:0] qa, qb;
    logic        stall, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_wb_regfile_sb dut (
        .clk(clk), .clrn(clrn),
        .WBwreg(WBwreg), .WBwn(WBwn), .WBdata(WBdata),
        .IDrs(IDrs), .IDrt(IDrt), .IDusesRs(IDusesRs), .IDusesRt(IDusesRt),
        .IDissue(IDissue), .IDwreg(IDwreg), .IDwn(IDwn),
        .qa(qa), .qb(qb), .stall(stall), .busy(busy)
    );

    typedef struct {
        string       name;
        logic        wb;
        logic [4:0]  wn;
        logic [31:0] wd;
        logic [4:0]  rs, rt;
        logic        urs, urt, iss, iwr;
        logic [4:0]  iwn;
        logic [31:0] eqa, eqb;
        logic        est, ebz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(string nm, logic wb, logic [4:0] wn, logic [31:0] wd,
                               logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic iss, logic iwr, logic [4:0] iwn,
                               logic [31:0] eqa, logic [31:0] eqb, logic est, logic ebz);
        vec_t v;
        v.name = nm; v.wb = wb; v.wn = wn; v.wd = wd; v.rs = rs; v.rt = rt;
        v.urs = urs; v.urt = urt; v.iss = iss; v.iwr = iwr; v.iwn = iwn;
        v.eqa = eqa; v.eqb = eqb; v.est = est; v.ebz = ebz;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        WBwreg = v.wb; WBwn = v.wn; WBdata = v.wd;
        IDrs = v.rs; IDrt = v.rt; IDusesRs = v.urs; IDusesRt = v.urt;
        IDissue = v.iss; IDwreg = v.iwr; IDwn = v.iwn;
    endtask

    task automatic idle();
        apply(V("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic chk_out(string nm, logic [31:0] eqa, logic [31:0] eqb, logic est, logic ebz);
        chk({nm, ".qa"}, qa, eqa);
        chk({nm, ".qb"}, qb, eqb);
        chk({nm, ".stall"}, {31'b0, stall}, {31'b0, est});
        chk({nm, ".busy"}, {31'b0, busy}, {31'b0, ebz});
    endtask

    initial begin
        //            name        wb wn  wdata          rs  rt  urs urt iss iwr iwn  eqa            eqb            st bz
        vecs.push_back(V("rd_r5",    0, 0, 0,             5,  0,  0, 0, 0, 0, 0,  0,             0,             0, 0));
        vecs.push_back(V("byp3",     1, 3, 32'hDEADBEEF,  3,  3,  0, 0, 0, 0, 0,  32'hDEADBEEF,  32'hDEADBEEF,  0, 0));
        vecs.push_back(V("arr3",     0, 0, 0,             3,  0,  0, 0, 0, 0, 0,  32'hDEADBEEF,  0,             0, 0));
        vecs.push_back(V("w_r0",     1, 0, 32'h1234,      0,  0,  0, 0, 0, 0, 0,  0,             0,             0, 0));
        vecs.push_back(V("rd_r0",    0, 0, 0,             0,  3,  0, 0, 0, 0, 0,  0,             32'hDEADBEEF,  0, 0));
        vecs.push_back(V("iss7",     0, 0, 0,             0,  0,  0, 0, 1, 1, 7,  0,             0,             0, 0));
        vecs.push_back(V("raw7",     0, 0, 0,             7,  0,  1, 0, 1, 0, 0,  0,             0,             1, 1));
        vecs.push_back(V("raw7_wb",  1, 7, 32'h55,        7,  0,  1, 0, 1, 0, 0,  32'h55,        0,             0, 1));
        vecs.push_back(V("idle7",    0, 0, 0,             7,  0,  0, 0, 0, 0, 0,  32'h55,        0,             0, 0));
        vecs.push_back(V("iss9",     0, 0, 0,             0,  0,  0, 0, 1, 1, 9,  0,             0,             0, 0));
        vecs.push_back(V("incdec9",  1, 9, 32'h99,        9,  0,  0, 0, 1, 1, 9,  32'h99,        0,             0, 1));
        vecs.push_back(V("still9",   0, 0, 0,             9,  0,  1, 0, 1, 0, 0,  32'h99,        0,             1, 1));
        vecs.push_back(V("ret9",     1, 9, 32'h77,        0,  0,  0, 0, 0, 0, 0,  0,             0,             0, 1));
        vecs.push_back(V("iss4a",    0, 0, 0,             0,  0,  0, 0, 1, 1, 4,  0,             0,             0, 0));
        vecs.push_back(V("iss4b",    0, 0, 0,             0,  0,  0, 0, 1, 1, 4,  0,             0,             0, 1));
        vecs.push_back(V("iss4c",    0, 0, 0,             0,  0,  0, 0, 1, 1, 4,  0,             0,             0, 1));
        vecs.push_back(V("sat4",     0, 0, 0,             0,  0,  0, 0, 1, 1, 4,  0,             0,             1, 1));
        vecs.push_back(V("sat4_ret", 1, 4, 32'h44,        4,  0,  0, 0, 1, 1, 4,  32'h44,        0,             1, 1));
        vecs.push_back(V("acc4",     0, 0, 0,             0,  0,  0, 0, 1, 1, 4,  0,             0,             0, 1));
        vecs.push_back(V("drain4a",  1, 4, 32'h41,        0,  0,  0, 0, 0, 0, 0,  0,             0,             0, 1));
        vecs.push_back(V("drain4b",  1, 4, 32'h42,        0,  0,  0, 0, 0, 0, 0,  0,             0,             0, 1));
        vecs.push_back(V("drain4c",  1, 4, 32'h43,        0,  4,  0, 0, 0, 0, 0,  0,             32'h43,        0, 1));
        vecs.push_back(V("untr12",   1, 12, 32'hA5,       12, 4,  0, 0, 0, 0, 0,  32'hA5,        32'h43,        0, 0));
        vecs.push_back(V("chk12",    0, 0, 0,             12, 12, 1, 1, 1, 0, 0,  32'hA5,        32'hA5,        0, 0));
        vecs.push_back(V("iss20",    0, 0, 0,             0,  0,  0, 0, 1, 1, 20, 0,             0,             0, 0));
        vecs.push_back(V("rt_haz",   0, 0, 0,             20, 20, 0, 1, 1, 0, 0,  0,             0,             1, 1));
        vecs.push_back(V("rt_nouse", 0, 0, 0,             0,  20, 0, 0, 1, 0, 0,  0,             0,             0, 1));
        vecs.push_back(V("noissue",  0, 0, 0,             0,  20, 1, 1, 0, 0, 0,  0,             0,             0, 1));

        clrn = 1'b0;
        idle();
        #2;
        chk_out("reset0", 0, 0, 0, 0);
        @(posedge clk);
        #2 clrn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #4;
            chk_out(vecs[i].name, vecs[i].eqa, vecs[i].eqb, vecs[i].est, vecs[i].ebz);
            @(posedge clk);
            #1;
        end

        // Mid-cycle reset with r20 pending and an active WB bypass onto the read port.
        apply(V("pre_rst", 1, 9, 32'hCAFE, 9, 20, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        #2;
        chk("pre_rst.qa", qa, 32'hCAFE);
        chk("pre_rst.stall", {31'b0, stall}, 32'd1);
        #1 clrn = 1'b0;
        #1;
        chk_out("mid_rst", 0, 0, 0, 0);
        WBwn = 5'd12; WBdata = 32'h3C; IDissue = 1'b0;
        #1 clrn = 1'b1;
        @(posedge clk);
        #1;
        // First edge after release wrote r12 with its counter held at zero.
        apply(V("post_rst", 0, 0, 0, 12, 9, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        #3;
        chk_out("post_rst", 32'h3C, 0, 0, 0);
        IDrs = 5'd20; IDrt = 5'd5;
        #1;
        chk("post_rst.r20", qa, 0);
        chk("post_rst.r5", qb, 0);
        @(posedge clk);
        #1;
        chk("post_rst.busy2", {31'b0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
